lu_result_fifo: RTL and testbench
=================================

LU_RESULT_FIFO -- requirements
Module: lu_result_fifo

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set the result width; it matches the logic-unit result width.
REQ-002 Parameter DEPTH, default 4, SHALL set the entry count; it must be a power of two and at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 flush  input  1  SHALL be the synchronous clear of the buffer contents.
REQ-006 in_valid  input  1  SHALL indicate that the upstream logic-unit result is presented.
REQ-007 in_ready  output  1  SHALL indicate that the buffer accepts a push this cycle.
REQ-008 in_data  input  DATA_W  SHALL carry the logic-unit result X.
REQ-009 in_op  input  2  SHALL carry the logic-unit select code C that produced in_data.
REQ-010 out_valid  output  1  SHALL indicate that the head entry is presented.
REQ-011 out_ready  input  1  SHALL indicate that the consumer takes the head entry.
REQ-012 out_data  output  DATA_W  SHALL present the head result.
REQ-013 out_op  output  2  SHALL present the head op tag.
REQ-014 out_zero  output  1  SHALL be high when out_valid is high and out_data equals 0.
REQ-015 out_ones  output  1  SHALL be high when out_valid is high and out_data is all ones.
REQ-016 count  output  clog2(DEPTH)+1  SHALL give the current occupancy.
REQ-017 full and empty  outputs  1 each  SHALL be the occupancy flags.
REQ-018 op_err  output  1  SHALL be the sticky error flag for constant-op data mismatch.

Function
REQ-019 A push SHALL occur when in_valid, in_ready and not flush are all high; a pop SHALL occur when out_valid, out_ready and not flush are all high.
REQ-020 in_ready SHALL equal not full, using registered occupancy; a pop in the same cycle SHALL NOT allow a push into a full buffer.
REQ-021 out_valid SHALL equal not empty.
REQ-022 out_data and out_op SHALL be driven from the storage entry at the read pointer.
REQ-023 Latency SHALL be one cycle: an entry pushed into an empty buffer is presented with out_valid high in the next cycle.
REQ-024 A simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-025 The read and write pointers SHALL wrap modulo DEPTH.
REQ-026 count SHALL change by +1 on a push only, by -1 on a pop only, and by 0 otherwise.
REQ-027 full SHALL be (count == DEPTH), and empty SHALL be (count == 0).
REQ-028 Op encodings SHALL be: OP_ONES=00 (result all ones), OP_OR=01, OP_ZERO=10 (result 0), OP_AND=11.
REQ-029 On an accepted push with in_op=OP_ONES and in_data not all ones, or with in_op=OP_ZERO and in_data not 0, op_err SHALL set the next cycle and hold until reset.
REQ-030 The mismatching entry SHALL still be stored.
REQ-031 flush SHALL set count to 0 and both pointers to 0 in the next cycle, SHALL take priority over a same-cycle push or pop, and SHALL NOT clear op_err.
REQ-032 Storage contents SHALL NOT be reset; out_data SHALL be don't-care while empty.

Reset
REQ-033 While rst is high, the next edge SHALL set count=0, both pointers=0 and op_err=0.
REQ-034 The resulting output values after that edge SHALL be: out_valid=0, in_ready=1, empty=1, full=0, out_zero=0, out_ones=0.
REQ-035 rst SHALL take priority over flush, push and pop; a reset mid-transfer SHALL discard all entries.

Structure
REQ-036 Package lu_pkg SHALL hold the OP_* constants, the DATA_W default and the op type; the logic unit and this block SHALL both import it.
REQ-037 Storage SHALL be a sub-module lu_fifo_ram (DEPTH x (DATA_W+2)), with synchronous write and combinational read.
REQ-038 The pointer, count and flag logic SHALL reside in lu_result_fifo.

Verification
REQ-039 Reset then push 4'b1010/OP_OR: out_valid=1 next cycle, out_data=1010, count=1, out_zero=0.
REQ-040 Push 0001, 0010, 0011, 0100 with out_ready=0: full=1, in_ready=0; a 5th push of 0101 is not stored; popping yields 0001, 0010, 0011, 0100 in order.
REQ-041 At count=2, push and pop in the same cycle: count stays 2; the output order after pointer wrap is preserved.
REQ-042 Push 4'b0000/OP_ZERO then 4'b1111/OP_ONES: the heads show out_zero=1, then out_ones=1; op_err stays 0.
REQ-043 Push 4'b0100/OP_ZERO: op_err=1 next cycle; a subsequent flush leaves op_err=1; a rst clears it.
REQ-044 At count=3, assert flush together with in_valid=1 and out_ready=1: next cycle count=0, empty=1, and the pushed data is discarded.

Source files
------------

// File: rtl/lu_pkg.sv
// Shared definitions for the logic unit and its result FIFO:
// op select encodings, default result width and the op type.
package lu_pkg;

    localparam int LU_DATA_W = 4;

    typedef enum logic [1:0] {
        OP_ONES = 2'b00,
        OP_OR   = 2'b01,
        OP_ZERO = 2'b10,
        OP_AND  = 2'b11
    } lu_op_e;

    // True when a constant-producing op came with data that contradicts it.
    function automatic logic lu_op_mismatch(input logic [1:0] op, input logic [31:0] data,
                                            input int width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        if (op == OP_ONES) return ((data & mask) != mask);
        if (op == OP_ZERO) return ((data & mask) != '0);
        return 1'b0;
    endfunction

endpackage

// File: rtl/lu_fifo_ram.sv
// Result storage: DEPTH entries of WIDTH bits, synchronous write and
// combinational read. Contents are intentionally not reset.
module lu_fifo_ram #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lu_result_fifo.sv
// Result FIFO behind the logic unit: buffers (result, op) pairs, flags
// constant-op results whose data contradicts the op, and decodes zero/ones heads.
module lu_result_fifo
    import lu_pkg::*;
#(
    parameter int DATA_W = LU_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [1:0]               out_op,
    output logic                     out_zero,
    output logic                     out_ones,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     op_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshake: a beat transfers on a cycle where valid and ready are both
    // high at the rising edge and flush is low; valid never waits on ready.

    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                op_err_q, op_err_d;
    logic                push, pop;
    logic [DATA_W+1:0]   rd_entry;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = count_q;
    assign op_err    = op_err_q;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        op_err_d = op_err_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            if (push && lu_op_mismatch(in_op, 32'(in_data), DATA_W)) op_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            op_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            op_err_q <= op_err_d;
        end
    end

    lu_fifo_ram #(
        .WIDTH (DATA_W + 2),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push && !rst),
        .waddr (wr_ptr_q),
        .wdata ({in_op, in_data}),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    assign out_op   = rd_entry[DATA_W+1:DATA_W];
    assign out_data = rd_entry[DATA_W-1:0];
    assign out_zero = out_valid && (out_data == '0);
    assign out_ones = out_valid && (&out_data);

endmodule

// File: tb/tb_lu_result_fifo.sv
// Scoreboard bench for lu_result_fifo: directed pushes feed an expected
// queue; a negedge monitor checks every popped head against it.
module tb_lu_result_fifo;
  import lu_pkg::*;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [1:0]        in_op = 2'b00;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_op;
  logic              out_zero, out_ones;
  logic [CW-1:0]     count;
  logic              full, empty, op_err;

  logic [DATA_W+1:0] exp_q[$];
  logic              exp_err = 1'b0;
  int                n_cmp = 0;
  int                n_err = 0;

  lu_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_op(out_op),
    .out_zero(out_zero), .out_ones(out_ones),
    .count(count), .full(full), .empty(empty), .op_err(op_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Acceptance is decided on registered occupancy, before any same-cycle pop.
  task automatic step();
    bit acc;
    bit bad;
    acc = in_valid && !flush && !rst && (exp_q.size() < DEPTH);
    bad = ((in_op == 2'b00) && (in_data != 4'hF)) || ((in_op == 2'b10) && (in_data != 4'h0));
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_err = 1'b0;
    end else if (flush) begin
      exp_q.delete();
    end else if (acc) begin
      exp_q.push_back({in_op, in_data});
      if (bad) exp_err = 1'b1;
    end
    #1;
  endtask

  task automatic push(input logic [3:0] d, input logic [1:0] op);
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step();
    out_ready = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_unexpected: got data %0h with empty expected queue", out_data);
        end else begin
          logic [DATA_W+1:0] e;
          e = exp_q.pop_front();
          check("out_data", int'(out_data), int'(e[DATA_W-1:0]));
          check("out_op", int'(out_op), int'(e[DATA_W+1:DATA_W]));
          check("out_zero", int'(out_zero), int'(e[DATA_W-1:0] == 4'h0));
          check("out_ones", int'(out_ones), int'(e[DATA_W-1:0] == 4'hF));
        end
      end
    end
  end

  initial begin
    // reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_zero", int'(out_zero), 0);
    check("rst_out_ones", int'(out_ones), 0);
    check("rst_op_err", int'(op_err), 0);

    // single push, one-cycle latency
    push(4'b1010, 2'b01);
    check("lat_out_valid", int'(out_valid), 1);
    check("lat_out_data", int'(out_data), 4'b1010);
    check("lat_count", int'(count), 1);
    check("lat_out_zero", int'(out_zero), 0);
    drain();
    check("drain1_empty", int'(empty), 1);

    // fill to full, overflow push is dropped
    push(4'b0001, 2'b01);
    push(4'b0010, 2'b11);
    push(4'b0011, 2'b01);
    push(4'b0100, 2'b11);
    check("full_flag", int'(full), 1);
    check("full_in_ready", int'(in_ready), 0);
    check("full_count", int'(count), 4);
    push(4'b0101, 2'b01);
    check("ovf_count", int'(count), 4);
    // pop while pushing into a full buffer: push must be refused
    out_ready = 1'b1;
    push(4'b0110, 2'b01);
    check("full_pop_push_count", int'(count), 3);
    drain();
    check("drain2_empty", int'(empty), 1);

    // simultaneous push/pop at count=2 across pointer wrap
    push(4'b1000, 2'b01);
    push(4'b1001, 2'b11);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(4'(4'hB + i), 2'b01);
      check("pp_count", int'(count), 2);
    end
    drain();

    // constant ops with matching data
    push(4'b0000, 2'b10);
    push(4'b1111, 2'b00);
    check("zero_head", int'(out_zero), 1);
    drain();
    check("const_op_err", int'(op_err), 0);

    // mismatching constant op: sticky error, kept over flush, cleared by rst
    push(4'b0100, 2'b10);
    check("err_set", int'(op_err), int'(exp_err));
    check("err_entry_stored", int'(count), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_keeps_err", int'(op_err), 1);
    check("flush_count", int'(count), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_clears_err", int'(op_err), int'(exp_err));

    // flush beats same-cycle push and pop
    push(4'b0111, 2'b01);
    push(4'b1100, 2'b11);
    push(4'b1101, 2'b01);
    check("pre_flush_count", int'(count), 3);
    flush = 1'b1;
    out_ready = 1'b1;
    push(4'b1110, 2'b01);
    flush = 1'b0;
    out_ready = 1'b0;
    check("post_flush_count", int'(count), 0);
    check("post_flush_empty", int'(empty), 1);
    step();
    check("post_flush_out_valid", int'(out_valid), 0);
    push(4'b0011, 2'b11);
    check("post_flush_head", int'(out_data), 4'b0011);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
